// File: rtl/scarv_soc_bram_bridge_pkg.sv
// ---------------------------------------------------------------------------
// scarv_soc_bram_bridge_pkg
//   Shared definitions for the bus-to-BRAM bridge: response entry width,
//   response buffer depth, strobe width, the response entry struct and a
//   helper that forms a response from the in-flight request flags.
//   No ports; imported by the interface, the response FIFO and the top.
// ---------------------------------------------------------------------------
package scarv_soc_bram_bridge_pkg;

    localparam int RSP_W      = 33;
    localparam int FIFO_DEPTH = 2;
    localparam int STRB_W     = 4;

    typedef struct packed {
        logic        error;
        logic [31:0] rdata;
    } rsp_t;

    // Write and error responses never carry BRAM data, so the read data
    // is forced to zero whenever either flag is set.
    function automatic rsp_t makeRsp(input logic err, input logic wr, input logic [31:0] rd);
        rsp_t r;
        r.error = err;
        r.rdata = (wr || err) ? 32'h0 : rd;
        return r;
    endfunction

endpackage

// File: rtl/scarv_soc_bram_bridge_if.sv
// ---------------------------------------------------------------------------
// scarv_soc_bram_bridge_if
//   SoC memory-bus port: req/gnt request channel and recv/ack response
//   channel.
//   master : drives mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack
//   slave  : drives mem_gnt, mem_recv, mem_error, mem_rdata
// ---------------------------------------------------------------------------
interface scarv_soc_bram_bridge_if;
    import scarv_soc_bram_bridge_pkg::*;

    logic              mem_req;
    logic              mem_gnt;
    logic              mem_wen;
    logic [STRB_W-1:0] mem_strb;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_recv;
    logic              mem_ack;
    logic              mem_error;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
        input  mem_gnt, mem_recv, mem_error, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_strb, mem_addr, mem_wdata, mem_ack,
        output mem_gnt, mem_recv, mem_error, mem_rdata
    );

endinterface

// File: rtl/scarv_soc_bram_bridge_rsp_fifo.sv
// ---------------------------------------------------------------------------
// scarv_soc_bram_bridge_rsp_fifo
//   Two-entry synchronous response buffer.
//   g_clk, g_resetn : clock, asynchronous active-low reset
//   push_i, pushData_i : write an entry
//   pop_i           : drop the head entry
//   head_o          : oldest entry (meaningful while count_o > 0)
//   count_o         : number of stored entries, 0..2
// ---------------------------------------------------------------------------
module scarv_soc_bram_bridge_rsp_fifo
    import scarv_soc_bram_bridge_pkg::*;
(
    input  logic       g_clk,
    input  logic       g_resetn,
    input  logic       push_i,
    input  rsp_t       pushData_i,
    input  logic       pop_i,
    output rsp_t       head_o,
    output logic [1:0] count_o
);

    logic [RSP_W-1:0] entry_q [FIFO_DEPTH];
    logic             wrPtr_q;
    logic             rdPtr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    // Occupancy only moves when exactly one of push/pop happens; a
    // simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + 2'd1;
        end else if (pop_i && !push_i) begin
            count_d = count_q - 2'd1;
        end
    end

    // Pointers and occupancy are reset so buffered responses are discarded.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) begin
                wrPtr_q <= ~wrPtr_q;
            end
            if (pop_i) begin
                rdPtr_q <= ~rdPtr_q;
            end
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was pushed.
    always_ff @(posedge g_clk) begin
        if (push_i) begin
            entry_q[wrPtr_q] <= pushData_i;
        end
    end

    assign head_o  = rsp_t'(entry_q[rdPtr_q]);
    assign count_o = count_q;

endmodule

// File: rtl/scarv_soc_bram_bridge.sv
// ---------------------------------------------------------------------------
// scarv_soc_bram_bridge
//   Adapts one SoC memory-bus port onto one BRAM port, absorbing the BRAM's
//   1-cycle read latency and response backpressure with a 2-entry buffer.
//   g_clk, g_resetn : clock, asynchronous active-low reset
//   mem             : bus port (slave side of scarv_soc_bram_bridge_if)
//   bram_en/we/addr/wdata : BRAM port controls
//   bram_rdata      : BRAM read data, valid the cycle after bram_en
//   Parameters: DEPTH (bytes), WRITE_EN (0 = ROM), BASE_ADDR.
//   Optional macro SCARV_SOC_BRAM_BRIDGE_RANGE_CHECK_EN: requests outside
//   [BASE_ADDR, BASE_ADDR+DEPTH) are answered with an error and never reach
//   the BRAM; without it upper address bits alias.
// ---------------------------------------------------------------------------
module scarv_soc_bram_bridge
    import scarv_soc_bram_bridge_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter int          WRITE_EN  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    scarv_soc_bram_bridge_if.slave     mem,
    output logic                       bram_en,
    output logic [STRB_W-1:0]          bram_we,
    output logic [$clog2(DEPTH)-1:0]   bram_addr,
    output logic [31:0]                bram_wdata,
    input  logic [31:0]                bram_rdata
);

    localparam int LW  = $clog2(DEPTH);
    localparam bit ROM = (WRITE_EN == 0);

    logic       gntEn_q;
    logic       inflight_q, inflight_d;
    logic       inflightWr_q, inflightWr_d;
    logic       inflightErr_q, inflightErr_d;
    logic       issue;
    logic       outOfRange;
    logic       bypass;
    logic       pushRsp;
    logic       popRsp;
    logic [1:0] count;
    rsp_t       inflightRsp;
    rsp_t       headRsp;

`ifdef SCARV_SOC_BRAM_BRIDGE_RANGE_CHECK_EN
    logic [31:0] offset;
    assign offset     = mem.mem_addr - BASE_ADDR;
    assign outOfRange = (offset >= 32'(DEPTH));
`else
    logic unusedAddr;
    assign unusedAddr = &{1'b0, mem.mem_addr[31:LW], BASE_ADDR};
    assign outOfRange = 1'b0;
`endif

    // Grant only depends on registered state: at most two responses can be
    // outstanding (buffered plus in flight), which guarantees buffer space.
    assign mem.mem_gnt = gntEn_q && (({1'b0, count} + {2'b00, inflight_q}) < 3'd2);
    assign issue       = mem.mem_req && mem.mem_gnt;

    assign bram_en    = issue && !outOfRange;
    assign bram_we    = (bram_en && mem.mem_wen && !ROM) ? mem.mem_strb : '0;
    assign bram_addr  = mem.mem_addr[LW-1:0];
    assign bram_wdata = mem.mem_wdata;

    // Flags for the request whose BRAM data arrives next cycle.
    always_comb begin
        inflight_d    = issue;
        inflightWr_d  = issue && mem.mem_wen;
        inflightErr_d = issue && ((mem.mem_wen && ROM) || outOfRange);
    end

    // gntEn_q holds grant off until the first clock after reset release.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            gntEn_q       <= 1'b0;
            inflight_q    <= 1'b0;
            inflightWr_q  <= 1'b0;
            inflightErr_q <= 1'b0;
        end else begin
            gntEn_q       <= 1'b1;
            inflight_q    <= inflight_d;
            inflightWr_q  <= inflightWr_d;
            inflightErr_q <= inflightErr_d;
        end
    end

    assign inflightRsp = makeRsp(inflightErr_q, inflightWr_q, bram_rdata);
    assign bypass      = (count == 2'd0);
    assign popRsp      = !bypass && mem.mem_ack;
    assign pushRsp     = inflight_q && !(bypass && mem.mem_ack);

    // With an empty buffer the in-flight response is presented directly;
    // otherwise the buffer head is presented so ordering is preserved.
    always_comb begin
        mem.mem_recv  = 1'b0;
        mem.mem_error = 1'b0;
        mem.mem_rdata = 32'h0;
        if (!bypass) begin
            mem.mem_recv  = 1'b1;
            mem.mem_error = headRsp.error;
            mem.mem_rdata = headRsp.rdata;
        end else if (inflight_q) begin
            mem.mem_recv  = 1'b1;
            mem.mem_error = inflightRsp.error;
            mem.mem_rdata = inflightRsp.rdata;
        end
    end

    scarv_soc_bram_bridge_rsp_fifo uRspFifo (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .push_i     (pushRsp),
        .pushData_i (inflightRsp),
        .pop_i      (popRsp),
        .head_o     (headRsp),
        .count_o    (count)
    );

endmodule

// File: tb/tb_scarv_soc_bram_bridge.sv
// ---------------------------------------------------------------------------
// tb_scarv_soc_bram_bridge
//   Drives a RAM bridge (WRITE_EN=1) and a ROM bridge (WRITE_EN=0) with the
//   same bus requests; each has its own BRAM model and expected-response
//   queue, and a monitor per bridge compares every accepted response.
// ---------------------------------------------------------------------------
module tb_scarv_soc_bram_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req, wen, ack;
    logic [3:0]  strb;
    logic [31:0] addr, wdata;

    int total = 0;
    int bad   = 0;

    logic [32:0] mQ[$];
    logic [32:0] rQ[$];
    logic [32:0] mHold, rHold;
    logic        mHoldV = 1'b0;
    logic        rHoldV = 1'b0;
    int          w;

    scarv_soc_bram_bridge_if mIf();
    scarv_soc_bram_bridge_if rIf();

    assign mIf.mem_req = req;   assign rIf.mem_req = req;
    assign mIf.mem_wen = wen;   assign rIf.mem_wen = wen;
    assign mIf.mem_strb = strb; assign rIf.mem_strb = strb;
    assign mIf.mem_addr = addr; assign rIf.mem_addr = addr;
    assign mIf.mem_wdata = wdata; assign rIf.mem_wdata = wdata;
    assign mIf.mem_ack = ack;   assign rIf.mem_ack = ack;

    logic        mEn, rEn;
    logic [3:0]  mWe, rWe;
    logic [9:0]  mAddr, rAddr;
    logic [31:0] mWdata, rWdata, mRdata, rRdata;
    logic [31:0] mMem [256];
    logic [31:0] rMem [256];

    scarv_soc_bram_bridge #(.DEPTH(1024), .WRITE_EN(1), .BASE_ADDR(32'h0)) dut (
        .g_clk(clk), .g_resetn(resetn), .mem(mIf),
        .bram_en(mEn), .bram_we(mWe), .bram_addr(mAddr),
        .bram_wdata(mWdata), .bram_rdata(mRdata)
    );

    scarv_soc_bram_bridge #(.DEPTH(1024), .WRITE_EN(0), .BASE_ADDR(32'h0)) romDut (
        .g_clk(clk), .g_resetn(resetn), .mem(rIf),
        .bram_en(rEn), .bram_we(rWe), .bram_addr(rAddr),
        .bram_wdata(rWdata), .bram_rdata(rRdata)
    );

    always #5 clk = ~clk;

    // BRAM models: registered read (old data on a same-cycle write), byte writes.
    always @(posedge clk) begin
        if (mEn) begin
            mRdata <= mMem[mAddr[9:2]];
            for (int b = 0; b < 4; b++)
                if (mWe[b]) mMem[mAddr[9:2]][8*b +: 8] <= mWdata[8*b +: 8];
        end
        if (rEn) begin
            rRdata <= rMem[rAddr[9:2]];
            for (int b = 0; b < 4; b++)
                if (rWe[b]) rMem[rAddr[9:2]][8*b +: 8] <= rWdata[8*b +: 8];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s actual=event expected=none", name);
    endtask

    // Issue one request on both bridges, check the BRAM port in the grant
    // cycle and queue the hand-computed responses.
    task automatic applyStimulus(
        input logic i_wen, input logic [3:0] i_strb, input logic [31:0] i_addr,
        input logic [31:0] i_wdata,
        input logic mExpEn, input logic [3:0] mExpWe, input logic [32:0] mExpRsp,
        input logic rExpEn, input logic [3:0] rExpWe, input logic [32:0] rExpRsp,
        output int waited);
        req = 1'b1; wen = i_wen; strb = i_strb; addr = i_addr; wdata = i_wdata;
        waited = 0;
        forever begin
            @(negedge clk);
            if (mIf.mem_gnt) break;
            waited++;
            if (waited > 40) begin
                reportFail("grant timeout");
                break;
            end
        end
        checkOutput("rom gnt", rIf.mem_gnt, 1);
        checkOutput("ram bram_en", mEn, mExpEn);
        checkOutput("ram bram_we", mWe, mExpWe);
        checkOutput("rom bram_en", rEn, rExpEn);
        checkOutput("rom bram_we", rWe, rExpWe);
        mQ.push_back(mExpRsp);
        rQ.push_back(rExpRsp);
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    // Response monitors: compare each accepted response in order and check
    // that an unaccepted response stays unchanged until it is accepted.
    always @(negedge clk) begin
        if (!resetn) begin
            mHoldV = 1'b0;
        end else if (mIf.mem_recv) begin
            if (mHoldV) checkOutput("ram hold", {mIf.mem_error, mIf.mem_rdata}, mHold);
            if (mIf.mem_ack) begin
                if (mQ.size() == 0) reportFail("ram unexpected rsp");
                else checkOutput("ram rsp", {mIf.mem_error, mIf.mem_rdata}, mQ.pop_front());
                mHoldV = 1'b0;
            end else begin
                mHold  = {mIf.mem_error, mIf.mem_rdata};
                mHoldV = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            rHoldV = 1'b0;
        end else if (rIf.mem_recv) begin
            if (rHoldV) checkOutput("rom hold", {rIf.mem_error, rIf.mem_rdata}, rHold);
            if (rIf.mem_ack) begin
                if (rQ.size() == 0) reportFail("rom unexpected rsp");
                else checkOutput("rom rsp", {rIf.mem_error, rIf.mem_rdata}, rQ.pop_front());
                rHoldV = 1'b0;
            end else begin
                rHold  = {rIf.mem_error, rIf.mem_rdata};
                rHoldV = 1'b1;
            end
        end
    end

    // Directed sequence.
    initial begin
        resetn = 1'b0; req = 1'b0; wen = 1'b0; strb = 4'h0;
        addr = 32'h0; wdata = 32'h0; ack = 1'b1;
        for (int i = 0; i < 256; i++) begin
            mMem[i] = 32'h0;
            rMem[i] = 32'h0;
        end
        mMem[0] = 32'h1111_1111; rMem[0] = 32'h1111_1111;
        mMem[1] = 32'h2222_2222; rMem[1] = 32'h2222_2222;
        mMem[2] = 32'h3333_3333; rMem[2] = 32'h3333_3333;
        mMem[4] = 32'hDEAD_BEEF; rMem[4] = 32'hDEAD_BEEF;
        mMem[8] = 32'hFFFF_FFFF; rMem[8] = 32'hFFFF_FFFF;

        #2;
        checkOutput("reset gnt", mIf.mem_gnt, 0);
        checkOutput("reset recv", mIf.mem_recv, 0);
        checkOutput("reset error", mIf.mem_error, 0);
        checkOutput("reset rdata", mIf.mem_rdata, 0);
        #10 resetn = 1'b1;
        #1 checkOutput("gnt before clock", mIf.mem_gnt, 0);
        @(posedge clk); #1;
        checkOutput("gnt after clock", mIf.mem_gnt, 1);

        $display("[TB] single read");
        applyStimulus(0, 4'h0, 32'h10, 0, 1, 4'h0, {1'b0, 32'hDEAD_BEEF}, 1, 4'h0, {1'b0, 32'hDEAD_BEEF}, w);
        checkOutput("latency recv", mIf.mem_recv, 1);
        checkOutput("latency rdata", mIf.mem_rdata, 32'hDEAD_BEEF);

        $display("[TB] back-to-back reads");
        applyStimulus(0, 4'h0, 32'h0, 0, 1, 4'h0, {1'b0, 32'h1111_1111}, 1, 4'h0, {1'b0, 32'h1111_1111}, w);
        checkOutput("b2b wait0", w, 0);
        applyStimulus(0, 4'h0, 32'h4, 0, 1, 4'h0, {1'b0, 32'h2222_2222}, 1, 4'h0, {1'b0, 32'h2222_2222}, w);
        checkOutput("b2b wait1", w, 0);
        applyStimulus(0, 4'h0, 32'h8, 0, 1, 4'h0, {1'b0, 32'h3333_3333}, 1, 4'h0, {1'b0, 32'h3333_3333}, w);
        checkOutput("b2b wait2", w, 0);
        @(posedge clk); #1;

        $display("[TB] backpressure");
        ack = 1'b0;
        applyStimulus(0, 4'h0, 32'h0, 0, 1, 4'h0, {1'b0, 32'h1111_1111}, 1, 4'h0, {1'b0, 32'h1111_1111}, w);
        applyStimulus(0, 4'h0, 32'h4, 0, 1, 4'h0, {1'b0, 32'h2222_2222}, 1, 4'h0, {1'b0, 32'h2222_2222}, w);
        checkOutput("bp second grant wait", w, 0);
        req = 1'b1; addr = 32'h8; wen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("bp gnt low", mIf.mem_gnt, 0);
            checkOutput("bp bram_en low", mEn, 0);
        end
        checkOutput("bp count", dut.uRspFifo.count_q, 2);
        checkOutput("bp head", mIf.mem_rdata, 32'h1111_1111);
        @(posedge clk); #1;
        ack = 1'b1;
        applyStimulus(0, 4'h0, 32'h8, 0, 1, 4'h0, {1'b0, 32'h3333_3333}, 1, 4'h0, {1'b0, 32'h3333_3333}, w);
        checkOutput("bp regrant wait", w, 1);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] write then read");
        applyStimulus(1, 4'b0011, 32'h20, 32'h1234_5678, 1, 4'b0011, {1'b0, 32'h0}, 1, 4'h0, {1'b1, 32'h0}, w);
        applyStimulus(0, 4'h0, 32'h20, 0, 1, 4'h0, {1'b0, 32'hFFFF_5678}, 1, 4'h0, {1'b0, 32'hFFFF_FFFF}, w);

        $display("[TB] zero-strobe write");
        applyStimulus(1, 4'h0, 32'h10, 32'hCAFE_F00D, 1, 4'h0, {1'b0, 32'h0}, 1, 4'h0, {1'b1, 32'h0}, w);
        applyStimulus(0, 4'h0, 32'h10, 0, 1, 4'h0, {1'b0, 32'hDEAD_BEEF}, 1, 4'h0, {1'b0, 32'hDEAD_BEEF}, w);

        $display("[TB] address at BASE_ADDR+DEPTH");
`ifdef SCARV_SOC_BRAM_BRIDGE_RANGE_CHECK_EN
        applyStimulus(0, 4'h0, 32'h400, 0, 0, 4'h0, {1'b1, 32'h0}, 0, 4'h0, {1'b1, 32'h0}, w);
`else
        applyStimulus(0, 4'h0, 32'h400, 0, 1, 4'h0, {1'b0, 32'h1111_1111}, 1, 4'h0, {1'b0, 32'h1111_1111}, w);
`endif
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset with full buffer");
        ack = 1'b0;
        applyStimulus(0, 4'h0, 32'h0, 0, 1, 4'h0, {1'b0, 32'h1111_1111}, 1, 4'h0, {1'b0, 32'h1111_1111}, w);
        applyStimulus(0, 4'h0, 32'h4, 0, 1, 4'h0, {1'b0, 32'h2222_2222}, 1, 4'h0, {1'b0, 32'h2222_2222}, w);
        @(posedge clk); #1;
        checkOutput("pre-reset count", dut.uRspFifo.count_q, 2);
        #2 resetn = 1'b0;
        #1;
        checkOutput("mid reset recv", mIf.mem_recv, 0);
        checkOutput("mid reset count", dut.uRspFifo.count_q, 0);
        checkOutput("mid reset gnt", mIf.mem_gnt, 0);
        mQ.delete();
        rQ.delete();
        #3 resetn = 1'b1;
        ack = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, 4'h0, 32'h10, 0, 1, 4'h0, {1'b0, 32'hDEAD_BEEF}, 1, 4'h0, {1'b0, 32'hDEAD_BEEF}, w);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("ram queue drained", mQ.size(), 0);
        checkOutput("rom queue drained", rQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
